// File: rtl/lc3_control_fsm_if.sv
// LC-3 control bundle: datapath status into the control FSM and the full set
// of load enables, bus gates, mux selects and memory strobes back out.
// master = control FSM side, slave = datapath side.
interface lc3_control_fsm_if;
  // Status / handshake from the datapath and front panel
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  // Register load enables
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;

  // Bus drivers (at most one active)
  logic GatePC, GateMDR, GateALU, GateMARMUX;

  // Mux selects and ALU function
  logic [1:0] PCMUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       DRMUX;
  logic [1:0] ALUK;

  // Memory strobes
  logic Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX, SR2MUX, DRMUX, ALUK,
    output Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX, SR2MUX, DRMUX, ALUK,
    input  Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 control FSM: sequences fetch / decode / execute for the 16-bit
// datapath. All control outputs are registered and are a pure decode of the
// state being entered, so they line up with state_q every cycle.
// Memory-access states hold their strobe for MEM_WAIT cycles using a wait
// counter that clears on every state change.
// Optional feature: define SINGLE_STEP_EN to stop in SS1/SS2 after each
// completed instruction until Continue is pulsed high then low.
module lc3_control_fsm #(
  parameter int MEM_WAIT = 3
) (
  input logic             Clk,
  input logic             Reset,
  lc3_control_fsm_if.master bus
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22, S12, S04, S21,
    S06, S07, S25, S27, S23, S16,
    P1, P2
`ifdef SINGLE_STEP_EN
    , SS1, SS2
`endif
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t END_STATE = SS1;
`else
  localparam state_t END_STATE = S18;
`endif

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       sr1mux, sr2mux, drmux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;

  // Next-state and wait-counter logic; the counter only advances while a
  // memory-access state is being held and is zero in every other state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      HALTED: if (bus.Run) state_d = S18;
      S18:    state_d = S33;
      S33:    if (cnt_q == CNT_LAST) state_d = S35; else cnt_d = cnt_q + CNT_ONE;
      S35:    state_d = S32;
      S32: begin
        case (bus.Opcode)
          4'b0001: state_d = S01;
          4'b0101: state_d = S05;
          4'b1001: state_d = S09;
          4'b0000: state_d = S00;
          4'b1100: state_d = S12;
          4'b0100: state_d = S04;
          4'b0110: state_d = S06;
          4'b0111: state_d = S07;
          4'b1101: state_d = P1;
          default: state_d = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27: state_d = END_STATE;
      S00:    state_d = bus.BEN ? S22 : END_STATE;
      S04:    state_d = S21;
      S06:    state_d = S25;
      S07:    state_d = S23;
      S25:    if (cnt_q == CNT_LAST) state_d = S27; else cnt_d = cnt_q + CNT_ONE;
      S23:    state_d = S16;
      S16:    if (cnt_q == CNT_LAST) state_d = END_STATE; else cnt_d = cnt_q + CNT_ONE;
      P1:     if (bus.Continue) state_d = P2;
      P2:     if (!bus.Continue) state_d = S18;
`ifdef SINGLE_STEP_EN
      SS1:    if (bus.Continue) state_d = SS2;
      SS2:    if (!bus.Continue) state_d = S18;
`endif
      default: state_d = HALTED;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs
  // always describe the current state; LD_MDR fires only on the final
  // cycle of a memory read.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S18: begin
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.ld_mar  = 1'b1;
        ctrl_d.ld_pc   = 1'b1;
      end
      S33, S25: begin
        ctrl_d.mem_oe = 1'b1;
        ctrl_d.ld_mdr = (cnt_d == CNT_LAST);
      end
      S35: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_ir    = 1'b1;
      end
      S32: ctrl_d.ld_ben = 1'b1;
      S01, S05: begin
        ctrl_d.sr2mux   = ~bus.IR_5;
        ctrl_d.aluk     = (state_d == S05) ? 2'b01 : 2'b00;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
      end
      S09: begin
        ctrl_d.aluk     = 2'b10;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
      end
      S22: begin
        ctrl_d.addr2mux = 2'b10;
        ctrl_d.pcmux    = 2'b10;
        ctrl_d.ld_pc    = 1'b1;
      end
      S12: begin
        ctrl_d.addr1mux = 1'b1;
        ctrl_d.pcmux    = 2'b10;
        ctrl_d.ld_pc    = 1'b1;
      end
      S04: begin
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.drmux   = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
      end
      S21: begin
        ctrl_d.pcmux = 2'b10;
        ctrl_d.ld_pc = 1'b1;
        if (bus.IR_11) begin
          ctrl_d.addr2mux = 2'b11;
        end else begin
          ctrl_d.addr1mux = 1'b1;
        end
      end
      S06, S07: begin
        ctrl_d.addr1mux    = 1'b1;
        ctrl_d.addr2mux    = 2'b01;
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.ld_mar      = 1'b1;
      end
      S27: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
      end
      S23: begin
        ctrl_d.sr1mux   = 1'b1;
        ctrl_d.aluk     = 2'b11;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_mdr   = 1'b1;
      end
      S16: ctrl_d.mem_we = 1'b1;
      P1:  ctrl_d.ld_led = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State, wait counter and outputs; reset drops everything to Halted with
  // all controls inactive, abandoning any instruction in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= HALTED;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.LD_MAR     = ctrl_q.ld_mar;
  assign bus.LD_MDR     = ctrl_q.ld_mdr;
  assign bus.LD_IR      = ctrl_q.ld_ir;
  assign bus.LD_BEN     = ctrl_q.ld_ben;
  assign bus.LD_CC      = ctrl_q.ld_cc;
  assign bus.LD_REG     = ctrl_q.ld_reg;
  assign bus.LD_PC      = ctrl_q.ld_pc;
  assign bus.LD_LED     = ctrl_q.ld_led;
  assign bus.GatePC     = ctrl_q.gate_pc;
  assign bus.GateMDR    = ctrl_q.gate_mdr;
  assign bus.GateALU    = ctrl_q.gate_alu;
  assign bus.GateMARMUX = ctrl_q.gate_marmux;
  assign bus.PCMUX      = ctrl_q.pcmux;
  assign bus.ADDR1MUX   = ctrl_q.addr1mux;
  assign bus.ADDR2MUX   = ctrl_q.addr2mux;
  assign bus.SR1MUX     = ctrl_q.sr1mux;
  assign bus.SR2MUX     = ctrl_q.sr2mux;
  assign bus.DRMUX      = ctrl_q.drmux;
  assign bus.ALUK       = ctrl_q.aluk;
  assign bus.Mem_OE     = ctrl_q.mem_oe;
  assign bus.Mem_WE     = ctrl_q.mem_we;

endmodule
